decoder: RTL and testbench

Parameterised binary-to-N-line decoder producing a combinational 2^SEL_SIZE-bit select vector from a SEL_SIZE-bit index. Output polarity is set at elaboration: one-hot (active-high) or one-cold (active-low). A registered copy of the decoded vector, with asynchronous reset, is provided for synchronous consumers. It drives the register-file, port and interrupt select lines in the core.

---
 rtl/decoder.sv | 39 +++
 tb/tb_decoder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/decoder.sv
// rtl/decoder.sv - binary-to-N-line decoder with combinational and registered outputs
// oY is the live decode of iS; oQ is the same vector captured on iClk and cleared to the inactive pattern by iRst.
module decoder #(
  parameter int SEL_SIZE = 2,
  parameter bit ONE_COLD = 1'b0,
  localparam int OUT_SIZE = 2 ** SEL_SIZE
) (
  input  logic [SEL_SIZE-1:0] iS,
  output logic [OUT_SIZE-1:0] oY,
  input  logic                iClk,
  input  logic                iRst,
  output logic [OUT_SIZE-1:0] oQ
);

  localparam logic [OUT_SIZE-1:0] INACTIVE = {OUT_SIZE{ONE_COLD}};

  logic [OUT_SIZE-1:0] one_hot;
  logic [OUT_SIZE-1:0] q_d;
  logic [OUT_SIZE-1:0] q_q;

  always_comb begin
    one_hot     = '0;
    one_hot[iS] = 1'b1;
    // One-cold is simply the inverted one-hot vector.
    oY          = ONE_COLD ? ~one_hot : one_hot;
    q_d         = oY;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      q_q <= INACTIVE;
    end else begin
      q_q <= q_d;
    end
  end

  assign oQ = q_q;

endmodule

// File: tb/tb_decoder.sv
// tb/tb_decoder.sv - self-checking bench for decoder (one-hot, one-cold and 1-bit index variants)
module tb_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] s;
  logic [0:0] s1;
  logic [7:0] hot_y, hot_q, cold_y, cold_q;
  logic [1:0] w1_y, w1_q;

  int n_checks = 0;
  int n_fail   = 0;
  bit running  = 1'b0;

  // Model of the registered outputs: index seen at the last edge taken out of reset.
  bit have_sample    = 1'b0;
  int last_s         = 0;
  int last_s1        = 0;

  logic [7:0] hot_lit  [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] cold_lit [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  always #5 clk = ~clk;

  decoder #(.SEL_SIZE(3), .ONE_COLD(1'b0)) u_hot (
    .iS(s), .oY(hot_y), .iClk(clk), .iRst(rst), .oQ(hot_q)
  );

  decoder #(.SEL_SIZE(3), .ONE_COLD(1'b1)) u_cold (
    .iS(s), .oY(cold_y), .iClk(clk), .iRst(rst), .oQ(cold_q)
  );

  decoder #(1, 1'b0) u_w1 (s1, w1_y, clk, rst, w1_q);

  function automatic logic [7:0] decode(int idx, int n_lines, bit cold);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < n_lines; k++) r[k] = (k == idx) ? !cold : cold;
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst === 1'b0) begin
      last_s      = int'(s);
      last_s1     = int'(s1);
      have_sample = 1'b1;
    end
  end

  always @(posedge rst) have_sample = 1'b0;

  always @(negedge clk) begin
    if (running) begin
      check("model_hot_y",  hot_y,           decode(int'(s), 8, 1'b0));
      check("model_cold_y", cold_y,          decode(int'(s), 8, 1'b1));
      check("model_w1_y",   {6'b0, w1_y},    decode(int'(s1), 2, 1'b0));
      check("model_hot_q",  hot_q,  have_sample ? decode(last_s, 8, 1'b0) : 8'h00);
      check("model_cold_q", cold_q, have_sample ? decode(last_s, 8, 1'b1) : 8'hFF);
      check("model_w1_q",   {6'b0, w1_q}, have_sample ? decode(last_s1, 2, 1'b0) : 8'h00);
    end
  end

  initial begin
    rst = 1'b1;
    s   = 3'd0;
    s1  = 1'b0;
    #1;
    check("reset_hot_q",  hot_q,  8'h00);
    check("reset_cold_q", cold_q, 8'hFF);
    check("reset_hot_y",  hot_y,  8'h01);
    running = 1'b1;

    @(posedge clk); #2 rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2 s = 3'(i);
      #1;
      check("sweep_hot_y",  hot_y,  hot_lit[i]);
      check("sweep_cold_y", cold_y, cold_lit[i]);
    end

    @(posedge clk); #2 s = 3'd3;
    #1;
    check("latency_hot_y",      hot_y,  8'h08);
    check("latency_hot_q_old",  hot_q,  8'h80);
    check("latency_cold_q_old", cold_q, 8'h7F);
    @(posedge clk); #1;
    check("latency_hot_q_new",  hot_q,  8'h08);
    check("latency_cold_q_new", cold_q, 8'hF7);

    #1 rst = 1'b1;
    #1;
    check("async_rst_hot_q",  hot_q,  8'h00);
    check("async_rst_cold_q", cold_q, 8'hFF);
    repeat (3) @(posedge clk);
    #1;
    check("rst_held_hot_q",  hot_q,  8'h00);
    check("rst_held_cold_q", cold_q, 8'hFF);

    #1;
    s   = 3'd6;
    rst = 1'b0;
    #1;
    check("release_hot_q_hold", hot_q, 8'h00);
    @(posedge clk); #1;
    check("release_hot_q_load",  hot_q,  8'h40);
    check("release_cold_q_load", cold_q, 8'hBF);

    s1 = 1'b0;
    #1 check("w1_y_idx0", {6'b0, w1_y}, 8'h01);
    s1 = 1'b1;
    #1 check("w1_y_idx1", {6'b0, w1_y}, 8'h02);
    @(posedge clk); #1;
    check("w1_q_idx1", {6'b0, w1_q}, 8'h02);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
